// File: rtl/jesd_enc_8b10b_pkg.sv
//==============================================================================
// Package : jesd_8b10b_pkg
// Desc    : Shared constants and K-code legality check for the 8b/10b encoder.
// Rev     : 1.0
//==============================================================================
`default_nettype none

package jesd_8b10b_pkg;

    localparam logic       RD_MINUS  = 1'b0;
    localparam logic       RD_PLUS   = 1'b1;
    localparam logic [9:0] K28_5_RDM = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    function automatic logic is_legal_k(input logic [4:0] x, input logic [2:0] y);
        return (x == 5'd28) ||
               ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                                (x == 5'd29) || (x == 5'd30)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/jesd_enc_8b10b_enc.sv
//==============================================================================
// Module : enc_5b6b_3b4b
// Desc   : Combinational 5b/6b + 3b/4b encoder with running-disparity update.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module enc_5b6b_3b4b
    import jesd_8b10b_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       k_i,
    input  logic       rd_i,
    output logic [9:0] sym_o,
    output logic       rd_out_o,
    output logic       k_err_o
);

    logic [4:0] w_x;
    logic [2:0] w_y;
    logic       w_k28;
    logic [5:0] w_6b_m;
    logic [5:0] w_6b;
    logic       w_rd6;
    logic       w_alt7;
    logic [3:0] w_4b_m;
    logic       w_flip4;
    logic       w_k28_flip;
    logic [3:0] w_4b;

    assign k_err_o = k_i & ~is_legal_k(data_i[4:0], data_i[7:5]);

    // An illegal K is substituted by K28.5 before encoding.
    assign w_x   = k_err_o ? 5'd28 : data_i[4:0];
    assign w_y   = k_err_o ? 3'd5  : data_i[7:5];
    assign w_k28 = k_i & (w_x == 5'd28);

    // Tables hold the RD- column; RD+ is the complement where the code is RD-dependent.
    always_comb begin
        w_6b_m = 6'b000000;
        if (w_k28) begin
            w_6b_m = 6'b001111;
        end else begin
            case (w_x)
                5'd0:  w_6b_m = 6'b100111;
                5'd1:  w_6b_m = 6'b011101;
                5'd2:  w_6b_m = 6'b101101;
                5'd3:  w_6b_m = 6'b110001;
                5'd4:  w_6b_m = 6'b110101;
                5'd5:  w_6b_m = 6'b101001;
                5'd6:  w_6b_m = 6'b011001;
                5'd7:  w_6b_m = 6'b111000;
                5'd8:  w_6b_m = 6'b111001;
                5'd9:  w_6b_m = 6'b100101;
                5'd10: w_6b_m = 6'b010101;
                5'd11: w_6b_m = 6'b110100;
                5'd12: w_6b_m = 6'b001101;
                5'd13: w_6b_m = 6'b101100;
                5'd14: w_6b_m = 6'b011100;
                5'd15: w_6b_m = 6'b010111;
                5'd16: w_6b_m = 6'b011011;
                5'd17: w_6b_m = 6'b100011;
                5'd18: w_6b_m = 6'b010011;
                5'd19: w_6b_m = 6'b110010;
                5'd20: w_6b_m = 6'b001011;
                5'd21: w_6b_m = 6'b101010;
                5'd22: w_6b_m = 6'b011010;
                5'd23: w_6b_m = 6'b111010;
                5'd24: w_6b_m = 6'b110011;
                5'd25: w_6b_m = 6'b100110;
                5'd26: w_6b_m = 6'b010110;
                5'd27: w_6b_m = 6'b110110;
                5'd28: w_6b_m = 6'b001110;
                5'd29: w_6b_m = 6'b101110;
                5'd30: w_6b_m = 6'b011110;
                5'd31: w_6b_m = 6'b101011;
                default: w_6b_m = 6'b000000;
            endcase
        end
    end

    assign w_6b  = (rd_i && (($countones(w_6b_m) != 3) || (w_6b_m == 6'b111000)))
                   ? ~w_6b_m : w_6b_m;
    assign w_rd6 = rd_i ^ ($countones(w_6b_m) != 3);

    assign w_alt7 = (w_y == 3'd7) &&
                    (k_i ||
                     (!w_rd6 && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))) ||
                     ( w_rd6 && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14))));

    always_comb begin
        w_4b_m = 4'b0000;
        case (w_y)
            3'd0: w_4b_m = 4'b1011;
            3'd1: w_4b_m = 4'b1001;
            3'd2: w_4b_m = 4'b0101;
            3'd3: w_4b_m = 4'b1100;
            3'd4: w_4b_m = 4'b1101;
            3'd5: w_4b_m = 4'b1010;
            3'd6: w_4b_m = 4'b0110;
            3'd7: w_4b_m = w_alt7 ? 4'b0111 : 4'b1110;
            default: w_4b_m = 4'b0000;
        endcase
    end

    // K28.y neutral 4b codes are inverted when the 6b part left RD-.
    assign w_flip4    = w_rd6 && (($countones(w_4b_m) != 2) || (w_y == 3'd3));
    assign w_k28_flip = w_k28 && !w_rd6 &&
                        ((w_y == 3'd1) || (w_y == 3'd2) || (w_y == 3'd5) || (w_y == 3'd6));
    assign w_4b       = w_4b_m ^ {4{w_flip4 ^ w_k28_flip}};

    assign sym_o    = {w_6b, w_4b};
    assign rd_out_o = w_rd6 ^ ($countones(w_4b_m) != 2);

endmodule

`default_nettype wire

// File: rtl/jesd_enc_8b10b.sv
//==============================================================================
// Module : jesd_enc_8b10b
// Desc   : Per-lane JESD204B 8b/10b encoder, one registered symbol per valid octet.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module jesd_enc_8b10b
    import jesd_8b10b_pkg::*;
#(
    parameter logic INIT_RD = RD_MINUS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    input  logic       i_k,
    output logic       o_valid,
    output logic [9:0] o_symbol,
    output logic       o_rd,
    output logic       o_k_err
);

    logic       valid_q;
    logic [9:0] sym_q;
    logic       rd_q;
    logic       k_err_q;

    logic [9:0] sym_d;
    logic       rd_d;
    logic       k_err_d;

    enc_5b6b_3b4b u_enc (
        .data_i   (i_data),
        .k_i      (i_k),
        .rd_i     (rd_q),
        .sym_o    (sym_d),
        .rd_out_o (rd_d),
        .k_err_o  (k_err_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sym_q   <= 10'b0;
            rd_q    <= INIT_RD;
            k_err_q <= 1'b0;
        end else begin
            valid_q <= i_valid;
            if (i_valid) begin
                sym_q   <= sym_d;
                rd_q    <= rd_d;
                k_err_q <= k_err_d;
            end
        end
    end

    assign o_valid  = valid_q;
    assign o_symbol = sym_q;
    assign o_rd     = rd_q;
    assign o_k_err  = k_err_q;

endmodule

`default_nettype wire

// File: doc/jesd_enc_8b10b.md
# jesd_enc_8b10b

Per-lane 8b/10b encoder for the JESD204B transmit path, IEEE 802.3 Clause 36 code tables. Accepts one octet plus a control flag per valid cycle. Emits the registered 10-bit symbol and tracks running disparity (RD) internally. Its output symbol stream feeds the lane serializer and the downstream disparity tracker.

## Interface
Parameters:
- INIT_RD, 1'b0: RD after reset (0 = RD-, 1 = RD+).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- i_valid  input  1  octet strobe; inputs are sampled only when high.
- i_data  input  8  octet HGF EDCBA; i_data[7] = H, i_data[0] = A.
- i_k  input  1  1 = control character K.x.y; 0 = data character D.x.y.
- o_valid  output  1  i_valid delayed one cycle.
- o_symbol  output  10  {a,b,c,d,e,i,f,g,h,j}; o_symbol[9] = a, transmitted first.
- o_rd  output  1  RD after o_symbol (0 = RD-, 1 = RD+).
- o_k_err  output  1  i_k was set with an illegal K code; qualified by o_valid.

## Operation
- Internal state: RD register `rd`, initialised to INIT_RD.
- 5b/6b stage:
  - Encode EDCBA using the current `rd`.
  - Intermediate disparity `rd6` = `rd` if the 6b sub-block is neutral; otherwise it is inverted. A 6b sub-block has either 3 ones, or 4/2 ones chosen per RD.
- 3b/4b stage:
  - Encode HGF using `rd6`.
  - Final RD = `rd6` if the 4b sub-block is neutral; otherwise inverted.
- Alternate D.x.A7 rule:
  - Use 0111 instead of 1110 when `rd6`=RD- and x ∈ {17,18,20}.
  - Use 1000 instead of 0001 when `rd6`=RD+ and x ∈ {11,13,14}.
  - Every other D.x.7 uses P7.
- K codes:
  - Legal codes are K28.0–K28.7, K23.7, K27.7, K29.7 and K30.7.
  - K28.y uses 001111/110000 for the 6b sub-block.
  - K.x.7 always uses 0111/1000 for the 4b sub-block.
- Illegal K:
  - o_k_err=1.
  - Symbol is replaced by K28.5 encoded at the current `rd`.
  - RD updates as for K28.5.
- i_valid=0:
  - o_valid=0.
  - o_symbol, o_rd and o_k_err hold their last values.
  - `rd` is unchanged.
- Invariant: every emitted symbol has 4, 5 or 6 ones. Cumulative disparity stays in {-1,+1} relative to INIT_RD.

## Timing
- Latency: 1 cycle, with no bubbles. An input sampled at edge N appears on the outputs after edge N, and back-to-back valid octets are sustained at full rate.
- Reset (asynchronous assert, synchronous deassert assumed upstream):
  - o_valid=0, o_symbol=10'b0, o_k_err=0, o_rd=INIT_RD, `rd`=INIT_RD.
- Reset mid-stream: the in-flight symbol is discarded. The first valid after reset is encoded from INIT_RD.
- o_rd always equals `rd` (registered together with o_symbol).
- No backpressure. Data has no illegal codes; only i_k is checked.

## Structure
- Package jesd_8b10b_pkg:
  - RD_MINUS/RD_PLUS constants.
  - K28_5_RDM = 10'b0011111010 and K28_5_RDP = 10'b1100000101.
  - Function is_legal_k(x, y).
- Sub-module enc_5b6b_3b4b:
  - Purely combinational.
  - Inputs: {data, k, rd}.
  - Outputs: {sym, rd_out, k_err}.
  - Holds both tables and the A7 logic.
- Top level: i_valid gating plus the output and RD registers.

## Test plan
- Reset released, then D.0.0 (i_data=8'h00, i_k=0) → o_symbol=10'b1001110100, o_rd=0, o_k_err=0, one cycle later.
- K28.5 (8'hBC, i_k=1) issued twice back-to-back from RD- → 10'b0011111010 (o_rd=1), then 10'b1100000101 (o_rd=0).
- D.21.5 (8'hB5) from RD- → 10'b1010101010, o_rd stays 0; gapped i_valid for 3 cycles → outputs held, o_valid=0.
- D.17.7 (8'hF1) from RD- → 10'b1000110111, o_rd=1; D.17.7 repeated from RD+ → 10'b1000110001, o_rd=0.
- Illegal K (8'h00, i_k=1) from RD- → o_k_err=1, o_symbol=10'b0011111010, o_rd=1.
- Random 10k octets with i_valid dithered, compared against a reference model → exact symbol match; every symbol has 4–6 ones and RD alternates correctly; rst_n asserted mid-stream → outputs reset immediately, restart from INIT_RD.
